fetch_wf_arbiter: RTL

- Round-robin selector for the fetch stage. Each cycle it picks one of up to 40 wavefronts that are requesting an instruction fetch.
- Presents the winner as a registered 6-bit wavefront ID with a valid/ready handshake. The ID is consumed directly by the downstream 6-to-40 one-hot wavefront decoder and the fetch request path.
- Tracks which wavefronts already have a fetch outstanding, so a wavefront is never granted twice before its fetch completes.

---
 rtl/fetch_wf_arbiter_pkg.sv | 22 ++
 rtl/fetch_wf_arbiter_rr_pick.sv | 54 +++++
 rtl/fetch_wf_arbiter.sv | 104 ++++++++++
 3 files changed

// File: rtl/fetch_wf_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_wf_arbiter_pkg
// Description : Shared fetch-stage constants and wavefront-ID types. These are
//               also used by the one-hot wavefront decoder, the instruction
//               buffer and the wave-pool logic.
// Contents    : FETCH_NUM_WF  - number of wavefront slots
//               FETCH_WF_ID_W - width of a wavefront ID
//               wf_id_t       - wavefront ID type
//               wf_mask_t     - per-wavefront bit mask type
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_wf_arbiter_pkg;

    localparam int FETCH_NUM_WF  = 40;
    localparam int FETCH_WF_ID_W = 6;

    typedef logic [FETCH_WF_ID_W-1:0] wf_id_t;
    typedef logic [FETCH_NUM_WF-1:0]  wf_mask_t;

endpackage : fetch_wf_arbiter_pkg
`default_nettype wire

// File: rtl/fetch_wf_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : fetch_rr_pick
// Description : Combinational round-robin picker. Rotates the eligibility
//               mask so that rr_ptr lands at bit 0, finds the lowest set bit,
//               then maps that position back to a wavefront ID. The wrap is at
//               NUM_WF, not at 2^WF_ID_W.
// Ports       : elig     in  NUM_WF   eligible wavefronts
//               rr_ptr   in  WF_ID_W  search start position (< NUM_WF)
//               winner   out WF_ID_W  selected wavefront ID
//               any_elig out 1        at least one wavefront eligible
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_rr_pick
    import fetch_wf_arbiter_pkg::*;
#(
    parameter int NUM_WF  = FETCH_NUM_WF,
    parameter int WF_ID_W = FETCH_WF_ID_W
) (
    input  logic [NUM_WF-1:0]  elig,
    input  logic [WF_ID_W-1:0] rr_ptr,
    output logic [WF_ID_W-1:0] winner,
    output logic               any_elig
);

    logic [NUM_WF-1:0]  rot;
    logic [WF_ID_W-1:0] rot_idx;
    logic [WF_ID_W:0]   sum;

    // Rotate right by rr_ptr within an NUM_WF-wide ring; the left-shift term
    // brings the bits below rr_ptr around to the top.
    assign rot = (elig >> rr_ptr) | (elig << (NUM_WF - int'(rr_ptr)));

    // Lowest set bit wins (loop runs high to low so the last hit is lowest).
    always_comb begin
        rot_idx = '0;
        for (int i = NUM_WF - 1; i >= 0; i--) begin
            if (rot[i]) begin
                rot_idx = WF_ID_W'(i);
            end
        end
    end

    // Un-rotate: add the pointer back, folding modulo NUM_WF. One extra bit
    // holds the carry since rot_idx + rr_ptr can reach 2*NUM_WF-2.
    assign sum    = {1'b0, rot_idx} + {1'b0, rr_ptr};
    assign winner = (sum >= (WF_ID_W+1)'(NUM_WF))
                  ? WF_ID_W'(sum - (WF_ID_W+1)'(NUM_WF))
                  : WF_ID_W'(sum);

    assign any_elig = |elig;

endmodule : fetch_rr_pick
`default_nettype wire

// File: rtl/fetch_wf_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fetch_wf_arbiter
// Description : Round-robin fetch-stage wavefront arbiter. Presents a
//               registered wavefront ID with a valid/ready handshake, never
//               retracts a presented grant, and keeps an outstanding mask so a
//               wavefront is not granted again until its fetch completes.
// Ports       : clk             in  1        rising-edge clock
//               rst_n           in  1        asynchronous active-low reset
//               fetch_req       in  NUM_WF   per-wavefront fetch request
//               fetch_ready     in  1        downstream accepts fetch_wfid
//               fetch_done      in  1        a granted fetch completed
//               fetch_done_wfid in  WF_ID_W  ID of the completed fetch
//               fetch_valid     out 1        fetch_wfid holds a valid grant
//               fetch_wfid      out WF_ID_W  granted wavefront ID
//               outstanding     out NUM_WF   fetch-in-flight mask
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_wf_arbiter
    import fetch_wf_arbiter_pkg::*;
#(
    parameter int NUM_WF  = FETCH_NUM_WF,
    parameter int WF_ID_W = FETCH_WF_ID_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_WF-1:0]  fetch_req,
    input  logic               fetch_ready,
    input  logic               fetch_done,
    input  logic [WF_ID_W-1:0] fetch_done_wfid,
    output logic               fetch_valid,
    output logic [WF_ID_W-1:0] fetch_wfid,
    output logic [NUM_WF-1:0]  outstanding
);

    logic               acc;
    logic               load;
    logic [NUM_WF-1:0]  grant_oh;
    logic [NUM_WF-1:0]  done_oh;
    logic [NUM_WF-1:0]  set_mask;
    logic [NUM_WF-1:0]  clr_mask;
    logic [NUM_WF-1:0]  elig;
    logic [WF_ID_W-1:0] rr_ptr;
    logic [WF_ID_W-1:0] winner;
    logic               any_elig;

    assign acc  = fetch_valid & fetch_ready;
    assign load = ~fetch_valid | fetch_ready;

    // One-hot decodes. IDs >= NUM_WF match no bit, so an out-of-range
    // fetch_done_wfid is dropped without an explicit range check.
    always_comb begin
        grant_oh = '0;
        done_oh  = '0;
        for (int i = 0; i < NUM_WF; i++) begin
            grant_oh[i] = (fetch_wfid == WF_ID_W'(i));
            done_oh[i]  = (fetch_done_wfid == WF_ID_W'(i));
        end
    end

    assign set_mask = acc        ? grant_oh : '0;
    assign clr_mask = fetch_done ? done_oh  : '0;

    // The wavefront being accepted this cycle is not yet in outstanding, so
    // it is masked explicitly to keep it from being re-granted at the same
    // edge. A completion this cycle is still seen as outstanding here.
    assign elig = fetch_req & ~outstanding & ~set_mask;

    fetch_rr_pick #(
        .NUM_WF  (NUM_WF),
        .WF_ID_W (WF_ID_W)
    ) u_pick (
        .elig     (elig),
        .rr_ptr   (rr_ptr),
        .winner   (winner),
        .any_elig (any_elig)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_valid <= 1'b0;
            fetch_wfid  <= '0;
            outstanding <= '0;
            rr_ptr      <= '0;
        end else begin
            if (load) begin
                fetch_valid <= any_elig;
                if (any_elig) begin
                    fetch_wfid <= winner;
                end
            end

            // Clear applied first so a same-ID set takes precedence.
            outstanding <= (outstanding & ~clr_mask) | set_mask;

            if (acc) begin
                rr_ptr <= (fetch_wfid == WF_ID_W'(NUM_WF - 1))
                        ? '0 : fetch_wfid + 1'b1;
            end
        end
    end

endmodule : fetch_wf_arbiter
`default_nettype wire
